// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if
// Groups the byte-write side and the serial/status side of uart_tx_buffer.
//   wr_data  [7:0]     byte to enqueue            (master -> slave)
//   wr_en              enqueue strobe             (master -> slave)
//   ovf_clr            clears the sticky ovf flag (master -> slave)
//   wr_full            FIFO holds DEPTH bytes     (slave -> master)
//   wr_count [ADDR_W:0] bytes queued, excluding the byte being shifted
//   ovf                sticky "a write was dropped"
//   uart_tx            8N1 serial line, idle high
//   tx_idle            FIFO empty and serializer idle
interface uart_tx_buffer_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            ovf_clr;
    logic            wr_full;
    logic [ADDR_W:0] wr_count;
    logic            ovf;
    logic            uart_tx;
    logic            tx_idle;

    modport master (
        output wr_data, wr_en, ovf_clr,
        input  wr_full, wr_count, ovf, uart_tx, tx_idle
    );

    modport slave (
        input  wr_data, wr_en, ovf_clr,
        output wr_full, wr_count, ovf, uart_tx, tx_idle
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
// Byte FIFO (2**ADDR_W entries) feeding an 8N1 UART serializer.
// Ports:
//   sys_clk  - sole clock, rising edge
//   reset_n  - asynchronous active-low reset; aborts any frame, empties FIFO
//   bus      - uart_tx_buffer_if.slave: write strobe/data, ovf/ovf_clr,
//              wr_full, wr_count, uart_tx, tx_idle
// The serial line is a register that reflects the serializer state present
// before each edge, so a byte accepted at edge N is popped at N+1 and the
// start bit appears at N+2. Consecutive frames are separated by one IDLE cycle.
module uart_tx_buffer #(
    parameter int CLK_DIV = 434,
    parameter int ADDR_W  = 4
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    uart_tx_buffer_if.slave    bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]     TMR_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    state_t            r_state;
    logic [15:0]       r_timer;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;

    logic w_full;
    logic w_pop;
    logic w_wr_acc;
    logic w_wr_drop;
    logic w_tmr_done;

    // Fullness is judged on the pre-edge count, so a write arriving in the
    // same cycle as a pop from a full FIFO is still dropped.
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_wr_acc   = bus.wr_en && !w_full;
    assign w_wr_drop  = bus.wr_en && w_full;
    assign w_tmr_done = (r_timer == TMR_LAST);

    // FIFO control
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as ovf_clr leaves the flag set.
            if (w_wr_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage and shift register carry no reset; control decides validity.
    always_ff @(posedge sys_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= bus.wr_data;
        end
        if (w_pop) begin
            r_shift <= r_mem[r_rptr];
        end else if ((r_state == S_DATA) && w_tmr_done) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // Serializer
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_timer <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_tmr_done) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_tmr_done) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tmr_done) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.uart_tx  = r_tx;
    assign bus.wr_full  = w_full;
    assign bus.wr_count = r_count;
    assign bus.ovf      = r_ovf;
    assign bus.tx_idle  = (r_count == '0) && (r_state == S_IDLE);
endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter CLK_DIV, default 434, sys_clk cycles per UART bit; legal range 2..65535.
REQ-002 Parameter ADDR_W, default 4; FIFO depth DEPTH = 2**ADDR_W bytes.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_en  input  1  enqueue strobe; one byte per cycle high.
REQ-007 wr_full  output  1  FIFO holds DEPTH bytes.
REQ-008 wr_count  output  ADDR_W+1  bytes currently queued, not counting the byte being shifted.
REQ-009 ovf  output  1  sticky flag: a write was dropped.
REQ-010 ovf_clr  input  1  clears ovf.
REQ-011 uart_tx  output  1  serial line, 8N1, idle high, registered output.
REQ-012 tx_idle  output  1  high when FIFO is empty and serializer is in IDLE.

Function
REQ-013 The FIFO SHALL be a circular buffer with ADDR_W-bit read/write pointers that wrap from DEPTH-1 to 0, plus an (ADDR_W+1)-bit count ranging 0..DEPTH.
REQ-014 A write SHALL be accepted when wr_en=1 and count<DEPTH: mem[wptr]<=wr_data, wptr+1.
REQ-015 A write with wr_en=1 and count==DEPTH SHALL be dropped and set ovf; fullness SHALL be judged on the pre-edge count, even when a pop occurs in the same cycle.
REQ-016 A pop SHALL occur only from serializer state IDLE when count>0.
REQ-017 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-018 If ovf_clr and a dropped write coincide, ovf SHALL end the cycle at 1 (set wins).
REQ-019 The serializer SHALL use states IDLE, START, DATA, STOP, with a bit-timer counting 0..CLK_DIV-1 and a 3-bit bit index.
REQ-020 IDLE transition: if count>0, load shift register with mem[rptr], rptr+1, clear timer, go to START; uart_tx=1 while in IDLE.
REQ-021 START transition: drive uart_tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
REQ-022 DATA transition: drive uart_tx=shift[0] (LSB first) for CLK_DIV cycles per bit and shift right after each bit; after bit 7 go to STOP.
REQ-023 STOP transition: drive uart_tx=1 for CLK_DIV cycles, then go to IDLE.
REQ-024 A frame SHALL last exactly 10*CLK_DIV cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle, giving a period of 10*CLK_DIV+1.
REQ-025 Latency: a write accepted at edge N to an empty, idle block SHALL produce the pop at edge N+1 and uart_tx low from edge N+2.
REQ-026 wr_full SHALL equal (count==DEPTH) and tx_idle SHALL equal (count==0 && state==IDLE), both derived from registered state.
REQ-027 Writes during a frame SHALL NOT disturb the byte being shifted.

Reset
REQ-028 While reset_n=0, regardless of clock: uart_tx=1, state=IDLE, pointers=0, count=0, wr_count=0, wr_full=0, ovf=0, tx_idle=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (line high), discard the frame and all queued bytes, and leave no partial frame after release.
REQ-030 The first write SHALL be accepted on the first rising edge after reset_n deasserts.

Verification (CLK_DIV=4, ADDR_W=2 unless noted)
REQ-031 Single byte: write 0xA5 at edge N -> uart_tx low from edge N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; tx_idle=1 afterward.
REQ-032 Back-to-back: write 0x00, 0xFF on consecutive cycles -> two frames with exactly 1 idle-high cycle between them (start-to-start spacing of 41 cycles); wr_count peaks at 1.
REQ-033 Overflow: while a frame is active, write 5 bytes -> first 4 accepted, wr_full=1, 5th dropped, ovf=1; pulse ovf_clr -> ovf=0; the 4 bytes are transmitted in order.
REQ-034 Simultaneous events: with count=4 and the pop occurring in the same cycle as a write -> write dropped, ovf=1, count=3; with count=2 plus write+pop in the same cycle -> count stays 2.
REQ-035 Pointer wrap: stream 10 distinct bytes while keeping the FIFO non-full -> the serial output matches the input order across two pointer wraps.
REQ-036 Reset mid-frame: assert reset_n=0 during DATA bit 3 with 2 bytes queued -> uart_tx=1 asynchronously, wr_count=0, tx_idle=1; no frame is emitted after release until a new write.
